// File: rtl/mb_fetch_gen.sv
// Macroblock fetch generator: streams raster-ordered pixel beats into Y, U and V
// arrays (4:2:0), with optional luma-only loads that fill chroma with mid-grey.
module mb_fetch_gen #(
    parameter int MB_W      = 16,
    parameter int MB_H      = 16,
    parameter int BUS_BYTES = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   fetch_start,
    input  logic                                   fetch_abort,
    input  logic                                   luma_only,
    input  logic [8*BUS_BYTES-1:0]                 data_word,
    input  logic                                   data_valid,
    output logic                                   data_ready,
    output logic [MB_W-1:0][MB_H-1:0][7:0]         pixel_y,
    output logic [MB_W/2-1:0][MB_H/2-1:0][7:0]     pixel_u,
    output logic [MB_W/2-1:0][MB_H/2-1:0][7:0]     pixel_v,
    output logic                                   fetch_busy,
    output logic                                   fetch_finish
);

    localparam int BEATS_Y = MB_W * MB_H / BUS_BYTES;
    localparam int BEATS_C = BEATS_Y / 4;
    localparam int BPR_Y   = MB_W / BUS_BYTES;
    localparam int BPR_C   = BPR_Y / 2;
    localparam int CNT_W   = $clog2(BEATS_Y);
    localparam int COL_W   = (BPR_Y > 1) ? $clog2(BPR_Y) : 1;
    localparam int ROW_W   = $clog2(MB_H);

    typedef enum logic [2:0] {
        StIdle,
        StLdY,
        StLdU,
        StLdV,
        StDone
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic               r_luma_only;
    logic               w_last;
    logic               w_col_last;
    logic               w_accept;
    logic               w_we_y;
    logic               w_we_u;
    logic               w_we_v;
    logic               w_fill;

    always_comb begin
        w_next_state = r_state;
        data_ready   = 1'b0;
        fetch_busy   = 1'b0;
        fetch_finish = 1'b0;
        w_last       = 1'b0;
        w_col_last   = 1'b0;
        case (r_state)
            StIdle: begin
                if (fetch_start && !fetch_abort) w_next_state = StLdY;
            end
            StLdY: begin
                data_ready = 1'b1;
                fetch_busy = 1'b1;
                w_last     = (r_cnt == CNT_W'(BEATS_Y - 1));
                w_col_last = (r_col == COL_W'(BPR_Y - 1));
                if (fetch_abort) begin
                    w_next_state = StIdle;
                end else if (data_valid && w_last) begin
                    w_next_state = r_luma_only ? StDone : StLdU;
                end
            end
            StLdU: begin
                data_ready = 1'b1;
                fetch_busy = 1'b1;
                w_last     = (r_cnt == CNT_W'(BEATS_C - 1));
                w_col_last = (r_col == COL_W'(BPR_C - 1));
                if (fetch_abort) begin
                    w_next_state = StIdle;
                end else if (data_valid && w_last) begin
                    w_next_state = StLdV;
                end
            end
            StLdV: begin
                data_ready = 1'b1;
                fetch_busy = 1'b1;
                w_last     = (r_cnt == CNT_W'(BEATS_C - 1));
                w_col_last = (r_col == COL_W'(BPR_C - 1));
                if (fetch_abort) begin
                    w_next_state = StIdle;
                end else if (data_valid && w_last) begin
                    w_next_state = StDone;
                end
            end
            StDone: begin
                fetch_busy   = 1'b1;
                fetch_finish = 1'b1;
                w_next_state = StIdle;
            end
            default: w_next_state = StIdle;
        endcase
    end

    assign w_accept = data_ready && data_valid && !fetch_abort;
    assign w_we_y   = w_accept && (r_state == StLdY);
    assign w_we_u   = w_accept && (r_state == StLdU);
    assign w_we_v   = w_accept && (r_state == StLdV);
    assign w_fill   = w_we_y && w_last && r_luma_only;

    // Beat counter plus column/row trackers; all restart on every state change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_luma_only <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == StIdle && w_next_state == StLdY) r_luma_only <= luma_only;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
                r_col <= '0;
                r_row <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pixel_y <= '0;
            pixel_u <= '0;
            pixel_v <= '0;
        end else begin
            for (int x = 0; x < MB_W; x++) begin
                for (int y = 0; y < MB_H; y++) begin
                    if (w_we_y && r_col == COL_W'(x / BUS_BYTES) && r_row == ROW_W'(y)) begin
                        pixel_y[x][y] <= data_word[8*(x % BUS_BYTES) +: 8];
                    end
                end
            end
            for (int x = 0; x < MB_W / 2; x++) begin
                for (int y = 0; y < MB_H / 2; y++) begin
                    if (w_fill) begin
                        pixel_u[x][y] <= 8'h80;
                        pixel_v[x][y] <= 8'h80;
                    end else if (r_col == COL_W'(x / BUS_BYTES) && r_row == ROW_W'(y)) begin
                        if (w_we_u) pixel_u[x][y] <= data_word[8*(x % BUS_BYTES) +: 8];
                        if (w_we_v) pixel_v[x][y] <= data_word[8*(x % BUS_BYTES) +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mb_fetch_gen.sv
// Scoreboard bench for mb_fetch_gen: loads push expected completions, a monitor
// checks latency, beat count and array contents on every fetch_finish pulse.
module tb_mb_fetch_gen;

    logic clk;
    logic rst, fetch_start, fetch_abort, luma_only, data_valid;
    logic [31:0] data_word;
    logic data_ready, fetch_busy, fetch_finish;
    logic [15:0][15:0][7:0] pixel_y;
    logic [7:0][7:0][7:0]   pixel_u, pixel_v;

    logic s_start, s_abort, s_lo, s_valid;
    logic [15:0] s1_word;
    logic [63:0] s2_word;
    logic s1_ready, s1_busy, s1_finish, s2_ready, s2_busy, s2_finish;
    logic [7:0][7:0][7:0]   s1_y;
    logic [3:0][3:0][7:0]   s1_u, s1_v;
    logic [15:0][15:0][7:0] s2_y;
    logic [7:0][7:0][7:0]   s2_u, s2_v;

    bit [7:0] m_y[16][16];
    bit [7:0] m_u[8][8];
    bit [7:0] m_v[8][8];
    int n_checks = 0, n_fail = 0, cyc = 0, acc = 0, acc1 = 0, acc2 = 0;

    typedef struct {int s; int lat; int beats; int off;} exp_t;
    exp_t q_main[$], q_s1[$], q_s2[$];

    mb_fetch_gen dut (
        .clk(clk), .rst(rst), .fetch_start(fetch_start), .fetch_abort(fetch_abort),
        .luma_only(luma_only), .data_word(data_word), .data_valid(data_valid),
        .data_ready(data_ready), .pixel_y(pixel_y), .pixel_u(pixel_u), .pixel_v(pixel_v),
        .fetch_busy(fetch_busy), .fetch_finish(fetch_finish)
    );

    mb_fetch_gen #(.MB_W(8), .MB_H(8), .BUS_BYTES(2)) dut_s1 (
        .clk(clk), .rst(rst), .fetch_start(s_start), .fetch_abort(s_abort),
        .luma_only(s_lo), .data_word(s1_word), .data_valid(s_valid),
        .data_ready(s1_ready), .pixel_y(s1_y), .pixel_u(s1_u), .pixel_v(s1_v),
        .fetch_busy(s1_busy), .fetch_finish(s1_finish)
    );

    mb_fetch_gen #(.BUS_BYTES(8)) dut_s2 (
        .clk(clk), .rst(rst), .fetch_start(s_start), .fetch_abort(s_abort),
        .luma_only(s_lo), .data_word(s2_word), .data_valid(s_valid),
        .data_ready(s2_ready), .pixel_y(s2_y), .pixel_u(s2_u), .pixel_v(s2_v),
        .fetch_busy(s2_busy), .fetch_finish(s2_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_main(input string tag);
        int by, bu, bv;
        by = 0; bu = 0; bv = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                if (pixel_y[x][y] !== m_y[x][y]) by++;
                if (x < 8 && y < 8) begin
                    if (pixel_u[x][y] !== m_u[x][y]) bu++;
                    if (pixel_v[x][y] !== m_v[x][y]) bv++;
                end
            end
        end
        check({tag, "_y_bad_bytes"}, by, 0);
        check({tag, "_u_bad_bytes"}, bu, 0);
        check({tag, "_v_bad_bytes"}, bv, 0);
    endtask

    // Raster reference: byte at (x,y) of a plane of width w is (y*w + x + off).
    task automatic cmp_sweep(input int inst, input int off);
        int by, bu, bv;
        by = 0; bu = 0; bv = 0;
        if (inst == 1) begin
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++)
                    if (s1_y[x][y] !== 8'(y * 8 + x + off)) by++;
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++) begin
                    if (s1_u[x][y] !== 8'(y * 4 + x + off)) bu++;
                    if (s1_v[x][y] !== 8'(y * 4 + x + off)) bv++;
                end
        end else begin
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    if (s2_y[x][y] !== 8'(y * 16 + x + off)) by++;
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++) begin
                    if (s2_u[x][y] !== 8'(y * 8 + x + off)) bu++;
                    if (s2_v[x][y] !== 8'(y * 8 + x + off)) bv++;
                end
        end
        check($sformatf("sweep%0d_y_bad_bytes", inst), by, 0);
        check($sformatf("sweep%0d_u_bad_bytes", inst), bu, 0);
        check($sformatf("sweep%0d_v_bad_bytes", inst), bv, 0);
    endtask

    // Monitor: counts accepted beats and scores each completion pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                acc = 0; acc1 = 0; acc2 = 0;
            end else begin
                if (fetch_start && !fetch_abort && !fetch_busy) acc = 0;
                if (data_valid && data_ready && !fetch_abort) acc++;
                if (s_start && !s_abort && !s1_busy) begin acc1 = 0; acc2 = 0; end
                if (s_valid && s1_ready && !s_abort) acc1++;
                if (s_valid && s2_ready && !s_abort) acc2++;
            end
            if (fetch_finish) begin
                if (q_main.size() == 0) begin
                    check("unexpected_finish", int'(fetch_finish), 0);
                end else begin
                    e = q_main.pop_front();
                    check("finish_latency", cyc - e.s + 1, e.lat);
                    check("accepted_beats", acc, e.beats);
                    cmp_main("finish");
                end
            end
            if (s1_finish) begin
                if (q_s1.size() == 0) begin
                    check("sweep1_unexpected_finish", int'(s1_finish), 0);
                end else begin
                    e = q_s1.pop_front();
                    check("sweep1_latency", cyc - e.s + 1, e.lat);
                    check("sweep1_beats", acc1, e.beats);
                    cmp_sweep(1, e.off);
                end
            end
            if (s2_finish) begin
                if (q_s2.size() == 0) begin
                    check("sweep2_unexpected_finish", int'(s2_finish), 0);
                end else begin
                    e = q_s2.pop_front();
                    check("sweep2_latency", cyc - e.s + 1, e.lat);
                    check("sweep2_beats", acc2, e.beats);
                    cmp_sweep(2, e.off);
                end
            end
        end
    end

    task automatic start_main(input bit lo, input int lat, input int beats, input bit expect_done);
        fetch_start = 1'b1;
        luma_only   = lo;
        if (expect_done) q_main.push_back('{cyc, lat, beats, 0});
        @(posedge clk); #1;
        fetch_start = 1'b0;
    endtask

    // Beat j: planes Y (0..63), U (64..79), V (80..95); byte b = 4*kp + b + off.
    task automatic drive_main(input int nbeats, input bit lo, input bit gap, input int off);
        for (int j = 0; j < nbeats; j++) begin
            int kp, tries, n;
            bit ok;
            kp = (j < 64) ? j : (j < 80) ? j - 64 : j - 80;
            for (int b = 0; b < 4; b++) data_word[8*b +: 8] = 8'(4 * kp + b + off);
            data_valid = 1'b1;
            tries = 0;
            ok = 1'b0;
            while (!ok && tries < 8) begin
                @(negedge clk);
                ok = data_ready;
                if (!ok) tries++;
                @(posedge clk); #1;
            end
            if (!ok) begin
                check("beat_ready_timeout", int'(data_ready), 1);
                data_valid = 1'b0;
                return;
            end
            for (int b = 0; b < 4; b++) begin
                n = 4 * kp + b;
                if (j < 64)      m_y[n % 16][n / 16] = 8'(n + off);
                else if (j < 80) m_u[n % 8][n / 8]   = 8'(n + off);
                else             m_v[n % 8][n / 8]   = 8'(n + off);
            end
            if (lo && j == 63) begin
                for (int x = 0; x < 8; x++)
                    for (int y = 0; y < 8; y++) begin
                        m_u[x][y] = 8'h80;
                        m_v[x][y] = 8'h80;
                    end
            end
            if (gap) begin
                data_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        data_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && (q_main.size() + q_s1.size() + q_s2.size()) > 0; i++)
            @(negedge clk);
        check("finish_pending", q_main.size() + q_s1.size() + q_s2.size(), 0);
        q_main.delete(); q_s1.delete(); q_s2.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; fetch_start = 1'b1; fetch_abort = 1'b0; luma_only = 1'b0;
        data_valid = 1'b1; data_word = '1;
        s_start = 1'b0; s_abort = 1'b0; s_lo = 1'b0; s_valid = 1'b0; s1_word = '0; s2_word = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_ready", int'(data_ready), 0);
        check("reset_busy", int'(fetch_busy), 0);
        check("reset_finish", int'(fetch_finish), 0);
        cmp_main("reset");
        @(posedge clk); #1;
        rst = 1'b1; fetch_start = 1'b0; data_valid = 1'b0;
        @(posedge clk); #1;

        // Full 4:2:0 load, back-to-back beats.
        start_main(1'b0, 98, 96, 1'b1);
        drive_main(96, 1'b0, 1'b0, 0);
        wait_drain();
        check("y_5_1", int'(pixel_y[5][1]), 21);
        check("u_0_0", int'(pixel_u[0][0]), 0);
        check("v_7_7", int'(pixel_v[7][7]), 63);
        check("idle_ready_after_load", int'(data_ready), 0);

        // Luma-only load fills chroma with 0x80.
        start_main(1'b1, 66, 64, 1'b1);
        drive_main(64, 1'b1, 1'b0, 7);
        wait_drain();
        check("luma_only_u_3_5", int'(pixel_u[3][5]), 128);
        check("luma_only_v_7_0", int'(pixel_v[7][0]), 128);
        check("luma_only_no_extra_beat", int'(data_ready), 0);
        check("luma_only_total_beats", acc, 64);

        // Alternating valid: same contents as the first load, longer latency.
        start_main(1'b0, 193, 96, 1'b1);
        drive_main(96, 1'b0, 1'b1, 0);
        wait_drain();
        check("gap_y_5_1", int'(pixel_y[5][1]), 21);
        check("gap_v_7_7", int'(pixel_v[7][7]), 63);

        // Abort alongside beat 10.
        start_main(1'b0, 0, 0, 1'b0);
        drive_main(10, 1'b0, 1'b0, 8'h40);
        for (int b = 0; b < 4; b++) data_word[8*b +: 8] = 8'(40 + b + 8'h40);
        data_valid = 1'b1;
        fetch_abort = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        fetch_abort = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(fetch_busy), 0);
        check("abort_ready", int'(data_ready), 0);
        cmp_main("abort");
        check("abort_beat10_dropped", int'(pixel_y[8][2]), 40);
        check("abort_row0_kept", int'(pixel_y[3][0]), 8'h43);
        repeat (3) @(posedge clk);
        #1;

        // Reload restarts from beat 0.
        start_main(1'b1, 66, 64, 1'b1);
        drive_main(64, 1'b1, 1'b0, 8'h11);
        wait_drain();
        check("reload_y_0_0", int'(pixel_y[0][0]), 8'h11);

        // Reset in the middle of a load.
        start_main(1'b0, 0, 0, 1'b0);
        drive_main(40, 1'b0, 1'b0, 8'h22);
        data_valid = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        data_valid = 1'b0;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
                m_y[x][y] = 8'h00;
                if (x < 8 && y < 8) begin
                    m_u[x][y] = 8'h00;
                    m_v[x][y] = 8'h00;
                end
            end
        @(negedge clk);
        check("midreset_ready", int'(data_ready), 0);
        check("midreset_busy", int'(fetch_busy), 0);
        cmp_main("midreset");
        @(posedge clk); #1;

        // Start and abort together in IDLE.
        fetch_start = 1'b1;
        fetch_abort = 1'b1;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        fetch_abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle_busy", int'(fetch_busy), 0);
        check("start_abort_idle_ready", int'(data_ready), 0);
        @(posedge clk); #1;

        // Parameter sweep: 8x8x2 and 16x16x8 both take 32+8+8 beats.
        s_start = 1'b1;
        q_s1.push_back('{cyc, 50, 48, 3});
        q_s2.push_back('{cyc, 50, 48, 3});
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int j = 0; j < 48; j++) begin
            int kp, tries;
            bit ok;
            kp = (j < 32) ? j : (j < 40) ? j - 32 : j - 40;
            for (int b = 0; b < 2; b++) s1_word[8*b +: 8] = 8'(2 * kp + b + 3);
            for (int b = 0; b < 8; b++) s2_word[8*b +: 8] = 8'(8 * kp + b + 3);
            s_valid = 1'b1;
            tries = 0;
            ok = 1'b0;
            while (!ok && tries < 8) begin
                @(negedge clk);
                ok = s1_ready && s2_ready;
                if (!ok) tries++;
                @(posedge clk); #1;
            end
            if (!ok) begin
                check("sweep_ready_timeout", int'(s1_ready && s2_ready), 1);
                break;
            end
        end
        s_valid = 1'b0;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
